// File: rtl/sha256_msg_feeder_if.sv
// Port bundle for sha256_msg_feeder: the incoming message word stream and the
// block handshake towards the SHA-256 core. The feeder uses the master modport.
interface sha256_msg_feeder_if;
    // Stream beat transfers on a clock edge where s_valid & s_ready are both high;
    // the source holds s_data/s_nbytes/s_last stable while s_valid waits for s_ready.
    logic [31:0]  s_data;
    logic [2:0]   s_nbytes;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] block;
    logic         next;
    logic         init;
    logic         core_ready;
    logic         digest_we;
    logic         busy;
    logic         done;
    logic [2:0]   state_dbg;

    modport master (
        input  s_data, s_nbytes, s_last, s_valid, core_ready, digest_we,
        output s_ready, block, next, init, busy, done, state_dbg
    );

    modport slave (
        output s_data, s_nbytes, s_last, s_valid, core_ready, digest_we,
        input  s_ready, block, next, init, busy, done, state_dbg
    );
endinterface

// File: rtl/sha256_msg_feeder.sv
// Packs a byte-aligned big-endian word stream into padded 512-bit SHA-256 blocks
// and issues them to the core one at a time with a next/init pulse.
module sha256_msg_feeder (
    input  logic                clk,
    input  logic                rst,
    sha256_msg_feeder_if.master bus
);
    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_PAD   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] blk_w [16];
    logic [3:0]  widx;
    logic [60:0] bytecnt;
    logic        pad_done, in_pad, last_blk, first, busy_q;
    logic        accept, fire, pad_set;
    logic [31:0] beat_word;
    logic [63:0] bit_len;

    assign bit_len       = {bytecnt, 3'b000};
    assign pad_set       = bus.s_last && (bus.s_nbytes < 3'd4);
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state;

    // Zero the invalid tail of the beat; a short final beat also carries the 0x80 marker.
    always_comb begin
        beat_word = 32'h0;
        case (bus.s_nbytes)
            3'd0:    beat_word = 32'h0;
            3'd1:    beat_word = {bus.s_data[31:24], 24'h0};
            3'd2:    beat_word = {bus.s_data[31:16], 16'h0};
            3'd3:    beat_word = {bus.s_data[31:8], 8'h0};
            default: beat_word = bus.s_data;
        endcase
        if (bus.s_last) begin
            case (bus.s_nbytes)
                3'd0:    beat_word[31:24] = 8'h80;
                3'd1:    beat_word[23:16] = 8'h80;
                3'd2:    beat_word[15:8]  = 8'h80;
                3'd3:    beat_word[7:0]   = 8'h80;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.block = '0;
        for (int i = 0; i < 16; i++) begin
            bus.block[511 - 32*i -: 32] = blk_w[i];
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.s_ready = 1'b0;
        bus.next    = 1'b0;
        bus.init    = 1'b0;
        bus.done    = 1'b0;
        accept      = 1'b0;
        fire        = 1'b0;
        case (state)
            S_FILL: begin
                bus.s_ready = !rst;
                accept      = bus.s_valid && !rst;
                if (accept) begin
                    if (widx == 4'd15)   state_nxt = S_ISSUE;
                    else if (bus.s_last) state_nxt = S_PAD;
                end
            end
            S_PAD: begin
                if ((widx == 4'd14) && pad_done) state_nxt = S_ISSUE;
                else if (widx == 4'd15)          state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                fire     = bus.core_ready && !rst;
                bus.next = fire;
                bus.init = first && fire;
                if (fire) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.digest_we) begin
                    if (last_blk)    state_nxt = S_DONE;
                    else if (in_pad) state_nxt = S_PAD;
                    else             state_nxt = S_FILL;
                end
            end
            S_DONE: begin
                bus.done  = !rst;
                state_nxt = S_FILL;
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FILL;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) blk_w[i] <= 32'h0;
            widx     <= 4'd0;
            bytecnt  <= '0;
            pad_done <= 1'b0;
            in_pad   <= 1'b0;
            last_blk <= 1'b0;
            first    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        blk_w[widx] <= beat_word;
                        bytecnt     <= bytecnt + 61'(bus.s_nbytes);
                        widx        <= widx + 4'd1;
                        busy_q      <= 1'b1;
                        if (pad_set)    pad_done <= 1'b1;
                        if (bus.s_last) in_pad   <= 1'b1;
                    end
                end
                S_PAD: begin
                    // Words 14/15 take the length only once the marker is already in place.
                    if ((widx == 4'd14) && pad_done) begin
                        blk_w[14] <= bit_len[63:32];
                        blk_w[15] <= bit_len[31:0];
                        last_blk  <= 1'b1;
                    end else begin
                        blk_w[widx] <= pad_done ? 32'h0 : 32'h8000_0000;
                        pad_done    <= 1'b1;
                        widx        <= widx + 4'd1;
                    end
                end
                S_ISSUE: begin
                    if (fire) first <= 1'b0;
                end
                S_WAIT: begin
                    if (bus.digest_we) begin
                        widx <= 4'd0;
                        if (last_blk) busy_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    widx     <= 4'd0;
                    bytecnt  <= '0;
                    pad_done <= 1'b0;
                    in_pad   <= 1'b0;
                    last_blk <= 1'b0;
                    first    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/sha256_msg_feeder.md
# sha256_msg_feeder

Host-side initiator for the SHA-256 core's block handshake. Accepts a byte-aligned message as a 32-bit big-endian word stream, applies FIPS 180-4 padding and the 64-bit bit-length trailer, assembles 512-bit blocks, and issues each block to the core with a one-cycle `next` pulse when the core reports ready. It waits for the core's `digest_we` before building the next block, and flags message completion.

## Interface
- No parameters.
- `clk`: input, 1 bit. Single clock.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `s_data`: input, 32 bits. Message word; first byte in [31:24].
- `s_nbytes`: input, 3 bits. Valid bytes in the beat. Must be 4 unless `s_last`; 0..4 allowed with `s_last`. Valid bytes are MSB-aligned.
- `s_last`: input, 1 bit. Final beat of the message.
- `s_valid`: input, 1 bit. Beat valid.
- `s_ready`: output, 1 bit. Beat accepted when `s_valid & s_ready`.
- `block`: output, 512 bits. Word 0 is in [511:480]. Held stable from `next` until `digest_we`.
- `next`: output, 1 bit. One-cycle block-start pulse to the core.
- `init`: output, 1 bit. Asserted with `next` for the first block of a message.
- `core_ready`: input, 1 bit. Core idle.
- `digest_we`: input, 1 bit. Core finished the current block.
- `busy`: output, 1 bit. High from the first accepted beat until `done`.
- `done`: output, 1 bit. One-cycle pulse when the final block's `digest_we` is seen.

## Operation
- States: FILL, PAD, ISSUE, WAIT, DONE.
- Internal registers:
  - `widx` (4 bits): word index into the block.
  - `bytecnt` (61 bits): message byte count.
  - `pad_done`: 0x80 byte has been placed.
  - `in_pad`: the last beat has been accepted.
  - `last_blk`: the block being issued is the final block.
  - `first`: next block is the first of a message.
- **FILL:** `s_ready`=1.
  - On handshake: `block[widx]` = data with invalid bytes zeroed. If `s_last` and `s_nbytes`<4, place 0x80 in the first invalid byte and set `pad_done`.
  - `bytecnt += s_nbytes`, `widx++`.
  - If `s_last`, set `in_pad`.
  - If old `widx`==15, go to ISSUE. Otherwise, if `s_last`, go to PAD.
- **PAD:** one word per cycle.
  - If `widx`==14 and `pad_done`: words 14/15 = `{bytecnt,3'b000}` (upper/lower); set `last_blk`; go to ISSUE.
  - Otherwise: write 0x80000000 if !`pad_done`, else 0; set `pad_done`; `widx++`. If old `widx`==15, go to ISSUE.
- **ISSUE:**
  - `next` = `core_ready` (combinational in this state only).
  - `init` = `first & next`.
  - When `next` fires: clear `first`, go to WAIT.
- **WAIT:** on `digest_we`:
  - If `last_blk`, go to DONE.
  - Else if `in_pad`, go to PAD with `widx`=0.
  - Else go to FILL with `widx`=0.
- **DONE:** `done`=1 for one cycle. Clear `in_pad`, `pad_done`, `last_blk`, `bytecnt`, `widx`; set `first`; go to FILL.
- The bit length is `bytecnt*8`, modulo 2^64. Messages ≥ 2^61 bytes are unsupported.
- `digest_we` outside WAIT and `core_ready` outside ISSUE are ignored.
- The block register is zeroed only by reset. Every word of each issued block is rewritten before issue.

## Timing
- Reset values: state FILL, `s_ready`=0 while `rst`=1, `next`=0, `init`=0, `done`=0, `busy`=0, `block`=0, all counters and flags 0, `first`=1.
- FILL accepts one beat per cycle with no bubbles. `s_ready` is low in PAD, ISSUE, WAIT and DONE.
- Last beat at `widx`=k (k≤13, `pad_done` set) to `next`: PAD spends (14−k−1) fill cycles plus 1 length cycle. `next` fires in the first ISSUE cycle with `core_ready`=1.
- `digest_we` in WAIT to `done`: 1 cycle.
- `digest_we` to the next FILL accept: 1 cycle.
- A `rst` asserted mid-message aborts it. No `next` or `done` is emitted after that.

## Test plan
- "abc": single beat 0x61626300, `s_nbytes`=3, `s_last`. Required: one `next` with `init`=1; word0=0x61626380, words1–14=0, word15=0x00000018. After `digest_we`, `done` pulses once.
- Empty message: one beat with `s_nbytes`=0, `s_last`. Required: word0=0x80000000, word15=0, one block.
- 56-byte message (14 full beats). Required: block 1 word14=0x80000000, word15=0, `init`=1. Block 2 words0–13=0, word15=0x000001C0, `init`=0. `done` only after the second `digest_we`.
- 64-byte message (16 beats, `s_last` on the 16th). Required: block 1 issued directly from FILL. Block 2 word0=0x80000000, word15=0x00000200.
- Backpressure: hold `core_ready`=0 for 10 cycles in ISSUE. Required: `next` stays 0 and `block` is unchanged. A spurious `digest_we` in ISSUE is ignored.
- Reset mid-message: assert `rst` after 5 beats, then send "abc". Required: the only block issued is the "abc" block with `init`=1, and `bytecnt` restarts from 0.
